// File: rtl/pulse_seq_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pulse_seq_pkg : state encoding and default widths for pulse_sequencer   |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
package pulse_seq_pkg;

  localparam int PERIOD_W_DEF = 16;
  localparam int COUNT_W_DEF  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | interval_timer : loadable down-counter, reloads itself when it hits 0   |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module interval_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] reload,
  output logic             zero
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Reloading at zero instead of decrementing means the counter never wraps.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = reload;
    end else if (enable) begin
      if (value_q == '0) value_d = reload;
      else               value_d = value_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign zero = (value_q == '0);

endmodule
`default_nettype wire

// File: rtl/pulse_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pulse_sequencer : emits COUNT single-cycle pulses PERIOD cycles apart   |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int COUNT_W  = COUNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  count,
  input  logic                abort,
  output logic                busy,
  output logic                pulse,
  output logic [COUNT_W-1:0]  index,
  output logic                done
);

  logic [1:0]          state_q,  state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0]  count_q,  count_d;
  logic [COUNT_W-1:0]  idx_q,    idx_d;
  logic [COUNT_W-1:0]  index_q,  index_d;
  logic                pulse_q,  pulse_d;
  logic                done_q,   done_d;
  logic                busy_q,   busy_d;

  logic [PERIOD_W-1:0] start_reload;
  logic [PERIOD_W-1:0] tmr_reload;
  logic                tmr_load;
  logic                tmr_en;
  logic                tmr_zero;

  interval_timer #(
    .WIDTH (PERIOD_W)
  ) u_interval_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .enable (tmr_en),
    .reload (tmr_reload),
    .zero   (tmr_zero)
  );

  // period 0 behaves like period 1; period_q holds P-1 directly.
  assign start_reload = (period == '0) ? '0 : period - PERIOD_W'(1);

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    count_d    = count_q;
    idx_d      = idx_q;
    index_d    = '0;
    pulse_d    = 1'b0;
    done_d     = 1'b0;
    busy_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_reload = period_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          period_d = start_reload;
          count_d  = count;
          idx_d    = '0;
          if (count != '0) begin
            state_d    = ST_RUN;
            busy_d     = 1'b1;
            tmr_load   = 1'b1;
            tmr_reload = start_reload;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          // busy stays up through the cycle showing the final pulse.
          busy_d = 1'b1;
          tmr_en = 1'b1;
          if (tmr_zero) begin
            pulse_d = 1'b1;
            index_d = idx_q;
            idx_d   = idx_q + COUNT_W'(1);
            if (idx_q == count_q - COUNT_W'(1)) state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        // A zero-count train already strobed done on entry.
        done_d  = ~done_q;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      index_q  <= '0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      index_q  <= index_d;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign pulse = pulse_q;
  assign index = index_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: doc/pulse_sequencer.md
# pulse_sequencer

Programmable pulse-train generator, the first device-under-test that the clock-driven testbench stage instantiates and drives. A start request latches a period and a repeat count. The block then emits `count` single-cycle pulses spaced `period` cycles apart, with a busy flag and a one-cycle done strobe. The testbench sequences and checks it entirely with `@(posedge clk)` loops.

## Interface
- `PERIOD_W`, 16, width of the period input and of the internal interval timer
- `COUNT_W`, 8, width of the repeat count and of the pulse index
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a new pulse train; accepted only in IDLE
- `period`  in  PERIOD_W  cycles between pulses; sampled with an accepted `start`
- `count`  in  COUNT_W  number of pulses; sampled with an accepted `start`
- `abort`  in  1  cancel a running train
- `busy`  out  1  high while in RUN
- `pulse`  out  1  one-cycle pulse, registered
- `index`  out  COUNT_W  0-based number of the current pulse; valid only while `pulse`=1
- `done`  out  1  one-cycle strobe after the last pulse of a completed train

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN: `start`=1 and `count`≠0.
  - IDLE→DONE: `start`=1 and `count`=0.
  - RUN→DONE: after the final pulse edge.
  - RUN→IDLE: `abort`=1.
  - DONE→IDLE: unconditional after one cycle.
- Period rule: `period`=0 is treated as 1.
  - Let P = max(`period`,1).
  - On accept, timer := P−1, remaining := `count`, idx := 0.
- Each RUN edge:
  - If timer≠0: timer decrements and `pulse` := 0.
  - Otherwise: `pulse` := 1, `index` := idx, idx increments, timer reloads to P−1.
  - If that was the last pulse (idx = count−1), next state is DONE.
- `start` in RUN or DONE is ignored. Latched `period` and `count` are unaffected by input changes after accept.
- Abort in RUN:
  - Takes effect at that edge: next state IDLE, `pulse` forced 0, no `done`.
  - Abort beats a pulse due on the same edge.
  - `abort` in IDLE or DONE is ignored.
- Reset:
  - Has priority over everything and aborts any train with no `done`.
  - State IDLE; `busy`, `pulse`, `done`, `index` = 0; timer and idx = 0.
- Arithmetic: the timer is PERIOD_W bits and never underflows, because reload occurs at 0. idx is COUNT_W bits; the maximum `count` = 2^COUNT_W−1, so idx never wraps within a train.

## Timing
- `start` accepted at edge k: `busy`=1 in the cycle after edge k.
- Pulse n (0-based) is high exactly in the cycle after edge k+(n+1)·P.
- After the last pulse, the next edge gives `busy`=0 and `done`=1 for one cycle. The edge after that returns to IDLE.
- Earliest new accept: the edge two cycles after the last pulse edge. That is: last pulse edge, DONE edge, then IDLE, where `start` is sampled.
- `count`=0: after edge k, `done`=1 for one cycle, `busy` stays 0, no pulses.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `pulse_seq_pkg`:
  - state encoding constants `ST_IDLE`=0, `ST_RUN`=1, `ST_DONE`=2 (2-bit);
  - default widths.
- One natural sub-module: `interval_timer`. It is a loadable down-counter with a `zero` flag and a `reload` input, instantiated once for the P-cycle spacing.
- The FSM, idx counter and output registers live in `pulse_sequencer`.

## Test plan
- P=3, C=4, start at edge 10:
  - `pulse` high after edges 13, 16, 19, 22 with `index` 0..3;
  - `done` after edge 23;
  - `busy` high after edges 10..22.
- `period`=0, C=3, start at edge 5:
  - pulses after edges 6, 7, 8 (same as P=1);
  - `done` after edge 9.
- C=0, start at edge 4: `done` after edge 4 only; `busy` and `pulse` never high.
- P=2, C=5, `abort` at edge 8 when start was at edge 0:
  - pulses after edges 2, 4, 6 only;
  - no pulse at 8, `busy` low after 8, no `done`.
- Second `start` with P=1, C=9 during a P=4, C=2 run: ignored; exactly 2 pulses at 4-cycle spacing, then `done`.
- `rst` pulsed mid-run:
  - all outputs 0 after the reset edge;
  - no `done`;
  - a fresh start after reset behaves per the first scenario.
